dram_cmd_responder: RTL and testbench

//  Synthesizable DRAM device-side responder for the controller's cmd_req/cmd/cmd_ack command port.

---
 rtl/dram_cmd_responder.sv | 209 ++++++++++++++++++++
 tb/tb_dram_cmd_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_cmd_responder.sv
// rtl/dram_cmd_responder.sv - timed DRAM device model answering the cmd_req/cmd/cmd_ack port
//
// Purpose: device-side responder for a DRAM controller command port. It decodes
// one-hot bank/row/col selects and keeps one open row per bank. Each command is
// acknowledged after a per-command latency. WRITE data is stored and READ data is
// returned. Illegal commands are acknowledged with cmd_err set.
//
// Ports:
//   clk        rising-edge clock
//   rst_b      asynchronous active-low reset
//   cmd_req    four-phase request from the controller
//   cmd        00 ACTIVATE, 01 READ, 10 WRITE, 11 PRECHARGE
//   bank_sel   one-hot bank select
//   row_sel    one-hot row select (ACTIVATE)
//   col_sel    one-hot column select (READ/WRITE)
//   wr_data    write data, sampled with the command
//   cmd_ack    four-phase acknowledge
//   cmd_err    command rejected, valid while cmd_ack=1
//   rd_data    read data, holds between reads
//   rd_valid   one-cycle strobe marking fresh rd_data
//   bank_open  per-bank open-row flags

module dram_cmd_responder #(
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int T_ACT        = 3,
  parameter int T_RW         = 2,
  parameter int T_PRE        = 2
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    cmd_req,
  input  logic [1:0]              cmd,
  input  logic [NUM_OF_BANKS-1:0] bank_sel,
  input  logic [NUM_OF_ROWS-1:0]  row_sel,
  input  logic [NUM_OF_COLS-1:0]  col_sel,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    cmd_ack,
  output logic                    cmd_err,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic [NUM_OF_BANKS-1:0] bank_open
);

  localparam int BW    = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1;
  localparam int RW    = (NUM_OF_ROWS  > 1) ? $clog2(NUM_OF_ROWS)  : 1;
  localparam int CW    = (NUM_OF_COLS  > 1) ? $clog2(NUM_OF_COLS)  : 1;
  localparam int T_AP  = (T_ACT > T_PRE) ? T_ACT : T_PRE;
  localparam int T_MAX = (T_AP > T_RW) ? T_AP : T_RW;
  localparam int CNTW  = $clog2(T_MAX + 1);

  localparam logic [1:0] CMD_ACT = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [1:0] CMD_PRE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNTW-1:0]         cnt_q;
  logic [1:0]              cmd_q;
  logic [BW-1:0]           bank_q;
  logic [RW-1:0]           row_q;
  logic [CW-1:0]           col_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    err_q;
  logic                    dropped_q;
  logic [RW-1:0]           open_row [NUM_OF_BANKS];
  logic [DATA_WIDTH-1:0]   mem [NUM_OF_BANKS][NUM_OF_ROWS][NUM_OF_COLS];

  logic [BW-1:0]           bank_idx;
  logic [RW-1:0]           row_idx;
  logic [CW-1:0]           col_idx;
  logic                    is_rw;
  logic                    sel_err;
  logic                    state_err;
  logic                    cap_err;
  logic [CNTW-1:0]         cap_lat;
  logic                    exec;

  // One-hot to binary; only meaningful when the matching select is one-hot,
  // which the error check guarantees before the index is ever used.
  always_comb begin
    bank_idx = '0;
    for (int i = 0; i < NUM_OF_BANKS; i++)
      if (bank_sel[i]) bank_idx = BW'(i);
  end

  always_comb begin
    row_idx = '0;
    for (int i = 0; i < NUM_OF_ROWS; i++)
      if (row_sel[i]) row_idx = RW'(i);
  end

  always_comb begin
    col_idx = '0;
    for (int i = 0; i < NUM_OF_COLS; i++)
      if (col_sel[i]) col_idx = CW'(i);
  end

  // Errors are judged at capture. Bank state cannot change while a command is
  // in flight, so the open/closed check made here still holds at execution.
  always_comb begin
    is_rw     = (cmd == CMD_RD) || (cmd == CMD_WR);
    sel_err   = !$onehot(bank_sel) ||
                ((cmd == CMD_ACT) && !$onehot(row_sel)) ||
                (is_rw && !$onehot(col_sel));
    state_err = ((cmd == CMD_ACT) && bank_open[bank_idx]) ||
                (is_rw && !bank_open[bank_idx]);
    cap_err   = sel_err || state_err;
    case (cmd)
      CMD_ACT: cap_lat = CNTW'(T_ACT - 1);
      CMD_PRE: cap_lat = CNTW'(T_PRE - 1);
      default: cap_lat = CNTW'(T_RW - 1);
    endcase
    if (cap_err) cap_lat = '0;
  end

  assign exec    = (state_q == S_BUSY) && (cnt_q == '0);
  assign cmd_ack = (state_q == S_ACK);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cmd_req) state_d = S_BUSY;
      S_BUSY: if (cnt_q == '0) state_d = S_ACK;
      // A request dropped early gets a single-cycle ack, whatever cmd_req does now.
      S_ACK:  if (!cmd_req || dropped_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q     <= '0;
      cmd_q     <= CMD_ACT;
      bank_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      dropped_q <= 1'b0;
      cmd_err   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      bank_open <= '0;
      for (int i = 0; i < NUM_OF_BANKS; i++) open_row[i] <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_req) begin
            cmd_q     <= cmd;
            bank_q    <= bank_idx;
            row_q     <= row_idx;
            col_q     <= col_idx;
            wdata_q   <= wr_data;
            err_q     <= cap_err;
            cnt_q     <= cap_lat;
            dropped_q <= 1'b0;
          end
        end
        S_BUSY: begin
          if (!cmd_req) dropped_q <= 1'b1;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNTW'(1);
          end else begin
            cmd_err <= err_q;
            if (!err_q) begin
              case (cmd_q)
                CMD_ACT: begin
                  bank_open[bank_q] <= 1'b1;
                  open_row[bank_q]  <= row_q;
                end
                CMD_RD: begin
                  rd_data  <= mem[bank_q][open_row[bank_q]][col_q];
                  rd_valid <= 1'b1;
                end
                CMD_PRE: bank_open[bank_q] <= 1'b0;
                default: ;
              endcase
            end
          end
        end
        S_ACK: if (state_d == S_IDLE) cmd_err <= 1'b0;
        default: ;
      endcase
    end
  end

  // Memory is deliberately not reset. While reset is held the FSM sits in IDLE,
  // so a write that was in flight never reaches this port.
  always_ff @(posedge clk) begin
    if (exec && !err_q && (cmd_q == CMD_WR))
      mem[bank_q][open_row[bank_q]][col_q] <= wdata_q;
  end

endmodule

// File: tb/tb_dram_cmd_responder.sv
// tb/tb_dram_cmd_responder.sv - directed and random checks of dram_cmd_responder against a reference model

module tb_dram_cmd_responder;

  localparam int NB = 8, NR = 128, NC = 8, DW = 8;
  localparam int T_ACT = 3, T_RW = 2, T_PRE = 2;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          cmd_req = 1'b0;
  logic [1:0]    cmd = 2'b00;
  logic [NB-1:0] bank_sel = '0;
  logic [NR-1:0] row_sel = '0;
  logic [NC-1:0] col_sel = '0;
  logic [DW-1:0] wr_data = '0;
  logic          cmd_ack, cmd_err, rd_valid;
  logic [DW-1:0] rd_data;
  logic [NB-1:0] bank_open;

  dram_cmd_responder #(
    .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC), .DATA_WIDTH(DW),
    .T_ACT(T_ACT), .T_RW(T_RW), .T_PRE(T_PRE)
  ) dut (
    .clk(clk), .rst_b(rst_b), .cmd_req(cmd_req), .cmd(cmd),
    .bank_sel(bank_sel), .row_sel(row_sel), .col_sel(col_sel), .wr_data(wr_data),
    .cmd_ack(cmd_ack), .cmd_err(cmd_err), .rd_data(rd_data), .rd_valid(rd_valid),
    .bank_open(bank_open)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: which banks are open, which row each holds, and every
  // location written so far (unwritten locations are unknown, reads of them
  // are not data-checked).
  logic [NB-1:0] m_open = '0;
  int            m_row [NB];
  logic [DW-1:0] m_mem [int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [NR-1:0] row_bit(input int r);
    logic [NR-1:0] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  // Full four-phase transaction with model prediction and output checks.
  task automatic do_cmd(input logic [1:0] c, input logic [NB-1:0] bs, input logic [NR-1:0] rs,
                        input logic [NC-1:0] cs, input logic [DW-1:0] wd, input string tag);
    bit            err;
    bit            exp_rv;
    bit            know;
    int            lat, b, k, n, hold;
    logic [DW-1:0] exp_rd;
    err    = ($countones(bs) != 1) ||
             (c == 2'd0 && $countones(rs) != 1) ||
             ((c == 2'd1 || c == 2'd2) && $countones(cs) != 1);
    b      = idx_of(NR'(bs));
    if (!err) begin
      if (c == 2'd0 && m_open[b]) err = 1;
      if ((c == 2'd1 || c == 2'd2) && !m_open[b]) err = 1;
    end
    lat    = err ? 1 : (c == 2'd0 ? T_ACT : (c == 2'd3 ? T_PRE : T_RW));
    exp_rv = !err && (c == 2'd1);
    know   = 0;
    exp_rd = '0;
    if (!err) begin
      case (c)
        2'd0: begin m_open[b] = 1'b1; m_row[b] = idx_of(rs); end
        2'd1: begin
          k = b * NR * NC + m_row[b] * NC + idx_of(NR'(cs));
          know = m_mem.exists(k);
          if (know) exp_rd = m_mem[k];
        end
        2'd2: begin
          k = b * NR * NC + m_row[b] * NC + idx_of(NR'(cs));
          m_mem[k] = wd;
        end
        default: m_open[b] = 1'b0;
      endcase
    end

    @(negedge clk);
    cmd = c; bank_sel = bs; row_sel = rs; col_sel = cs; wr_data = wd;
    cmd_req = 1'b1;
    @(posedge clk);
    #1;
    // Selects and data after capture must be ignored.
    cmd = 2'($urandom); bank_sel = NB'($urandom); row_sel = {4{$urandom}};
    col_sel = NC'($urandom); wr_data = DW'($urandom);
    n = 0;
    while (!cmd_ack && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, " latency"}, n, lat);
    chk({tag, " cmd_err"}, cmd_err, 32'(err));
    chk({tag, " rd_valid"}, rd_valid, 32'(exp_rv));
    if (exp_rv && know) chk({tag, " rd_data"}, rd_data, exp_rd);
    chk({tag, " bank_open"}, bank_open, m_open);
    hold = $urandom_range(0, 2);
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    if (hold > 0) begin
      chk({tag, " ack held"}, cmd_ack, 1);
      chk({tag, " rd_valid strobe"}, rd_valid, 0);
    end
    cmd_req = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, " ack release"}, cmd_ack, 0);
    chk({tag, " err release"}, cmd_err, 0);
  endtask

  initial begin
    int            n;
    logic [1:0]    rc;
    logic [NB-1:0] rbs;
    logic [NR-1:0] rrs;
    logic [NC-1:0] rcs;

    repeat (3) @(negedge clk);
    chk("reset cmd_ack", cmd_ack, 0);
    chk("reset cmd_err", cmd_err, 0);
    chk("reset rd_valid", rd_valid, 0);
    chk("reset rd_data", rd_data, 0);
    chk("reset bank_open", bank_open, 0);
    rst_b = 1'b1;
    @(negedge clk);

    do_cmd(2'd0, 8'h04, row_bit(5), 8'h00, 8'h00, "t1 act b2");
    do_cmd(2'd2, 8'h04, '0, 8'h08, 8'hA5, "t2 wr b2c3");
    do_cmd(2'd1, 8'h04, '0, 8'h08, 8'h00, "t2 rd b2c3");
    do_cmd(2'd1, 8'h40, '0, 8'h01, 8'h00, "t3 rd closed");
    do_cmd(2'd2, 8'h00, '0, 8'h08, 8'h11, "t5 wr bank0");
    do_cmd(2'd2, 8'h03, '0, 8'h08, 8'h22, "t5 wr bank2hot");
    do_cmd(2'd2, 8'h04, '0, 8'h00, 8'h33, "t5 wr col0");
    do_cmd(2'd1, 8'h04, '0, 8'h08, 8'h00, "t5 reread");
    do_cmd(2'd3, 8'h04, '0, 8'h00, 8'h00, "t4 pre b2");
    do_cmd(2'd0, 8'h04, row_bit(5), 8'h00, 8'h00, "t4 act r5");
    do_cmd(2'd0, 8'h04, row_bit(9), 8'h00, 8'h00, "t4 act r9");
    do_cmd(2'd3, 8'h04, '0, 8'h00, 8'h00, "t4 pre");
    do_cmd(2'd3, 8'h04, '0, 8'h00, 8'h00, "t4 pre again");
    do_cmd(2'd0, 8'h04, 128'h0, 8'h00, 8'h00, "act row0");

    // Request dropped during BUSY: command completes, ack lasts one cycle.
    @(negedge clk);
    cmd = 2'd0; bank_sel = 8'h01; row_sel = row_bit(1); cmd_req = 1'b1;
    @(posedge clk);
    #1;
    cmd_req = 1'b0;
    n = 0;
    while (!cmd_ack && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    m_open[0] = 1'b1; m_row[0] = 1;
    chk("drop latency", n, T_ACT);
    chk("drop bank_open", bank_open, m_open);
    @(posedge clk);
    #1;
    chk("drop ack one cycle", cmd_ack, 0);

    // Reset during WRITE BUSY discards the write.
    do_cmd(2'd0, 8'h04, row_bit(5), 8'h00, 8'h00, "t6 act");
    @(negedge clk);
    cmd = 2'd2; bank_sel = 8'h04; col_sel = 8'h08; wr_data = 8'h5A; cmd_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk("t6 ack in reset", cmd_ack, 0);
    chk("t6 bank_open in reset", bank_open, 0);
    cmd_req = 1'b0;
    m_open = '0;
    @(negedge clk);
    rst_b = 1'b1;
    do_cmd(2'd0, 8'h04, row_bit(5), 8'h00, 8'h00, "t6 react");
    do_cmd(2'd1, 8'h04, '0, 8'h08, 8'h00, "t6 reread");

    // Reset while ack is high drops it without a clock edge.
    @(negedge clk);
    cmd = 2'd1; bank_sel = 8'h04; col_sel = 8'h08; cmd_req = 1'b1;
    @(posedge clk);
    n = 0;
    #1;
    while (!cmd_ack && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ackrst rd_data", rd_data, 8'hA5);
    chk("ackrst ack high", cmd_ack, 1);
    @(negedge clk);
    #2;
    rst_b = 1'b0;
    #1;
    chk("ackrst ack async", cmd_ack, 0);
    chk("ackrst rd_data", rd_data, 0);
    cmd_req = 1'b0;
    m_open = '0;
    @(negedge clk);
    rst_b = 1'b1;

    for (int i = 0; i < 150; i++) begin
      rc  = 2'($urandom_range(0, 3));
      rbs = '0;
      rbs[$urandom_range(0, NB - 1)] = 1'b1;
      if ($urandom_range(0, 9) == 0) rbs = NB'($urandom);
      rrs = row_bit($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) rrs = row_bit(2) | row_bit(7);
      if ($urandom_range(0, 11) == 0) rrs = '0;
      rcs = '0;
      rcs[$urandom_range(0, NC - 1)] = 1'b1;
      if ($urandom_range(0, 11) == 0) rcs = NC'($urandom);
      do_cmd(rc, rbs, rrs, rcs, DW'($urandom), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
